// File: rtl/pipe_ctrl_if.sv
// Control/hazard unit bus: D-stage instruction and E-stage ALU flags in,
// stage selects plus stall/flush out.
interface pipe_ctrl_if;
  logic [31:0] instr_D;
  logic        alu_zero_E;
  logic        alu_lsb_E;
  logic [2:0]  imm_SEL;
  logic        rs1_SEL;
  logic        rs2_SEL;
  logic [3:0]  ALU_SEL;
  logic        mem_WE;
  logic [1:0]  pc_SEL;
  logic        reg_WE;
  logic [1:0]  reg_SEL;
  logic        stall_F, stall_D, stall_E, stall_M, stall_WB;
  logic        flush_D, flush_E, flush_M, flush_WB;
  logic        illegal_D;

  modport master (
    output instr_D, alu_zero_E, alu_lsb_E,
    input  imm_SEL, rs1_SEL, rs2_SEL, ALU_SEL, mem_WE, pc_SEL, reg_WE, reg_SEL,
    input  stall_F, stall_D, stall_E, stall_M, stall_WB,
    input  flush_D, flush_E, flush_M, flush_WB, illegal_D
  );

  modport slave (
    input  instr_D, alu_zero_E, alu_lsb_E,
    output imm_SEL, rs1_SEL, rs2_SEL, ALU_SEL, mem_WE, pc_SEL, reg_WE, reg_SEL,
    output stall_F, stall_D, stall_E, stall_M, stall_WB,
    output flush_D, flush_E, flush_M, flush_WB, illegal_D
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipelined RV32I control and hazard unit: decodes in D, carries control
// words through E/M/WB, and raises stall/flush for RAW hazards and redirects.
module pipe_ctrl #(
  parameter int unsigned RF_AW          = 5,
  parameter bit          NOP_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  pipe_ctrl_if.slave bus
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  typedef struct packed {
    logic       reg_we;
    logic [1:0] reg_sel;
  } cw_wb_t;

  typedef struct packed {
    logic             mem_we;
    logic             jump;
    logic             jumpr;
    logic             branch;
    logic [RF_AW-1:0] rd;
    cw_wb_t           wb;
  } cw_m_t;

  typedef struct packed {
    logic       rs1_sel;
    logic       rs2_sel;
    logic [3:0] alu_sel;
    logic [2:0] funct3;
    cw_m_t      m;
  } cw_e_t;

  logic [6:0]       w_opc;
  logic [2:0]       w_f3;
  logic [RF_AW-1:0] w_rd, w_rs1, w_rs2;
  logic [2:0]       w_imm_sel;
  logic             w_use_rs1, w_use_rs2, w_illegal;
  cw_e_t            w_cw;
  logic             w_raw, w_xfer, w_taken_E;
  logic [1:0]       w_pc_sel;
  logic             w_unused;

  cw_e_t  r_cw_E;
  cw_m_t  r_cw_M;
  cw_wb_t r_cw_WB;
  logic   r_taken_M;

  assign w_opc    = bus.instr_D[6:0];
  assign w_f3     = bus.instr_D[14:12];
  assign w_rd     = bus.instr_D[7 +: RF_AW];
  assign w_rs1    = bus.instr_D[15 +: RF_AW];
  assign w_rs2    = bus.instr_D[20 +: RF_AW];
  assign w_unused = ^{bus.instr_D[31], bus.instr_D[29:25]};

  // D-stage decode into the E control word
  always_comb begin
    w_cw      = '0;
    w_imm_sel = IMM_I;
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    w_illegal = 1'b0;
    case (w_opc)
      OPC_LUI: begin
        w_imm_sel = IMM_U; w_cw.m.wb = '{reg_we: 1'b1, reg_sel: 2'd2};
      end
      OPC_AUIPC: begin
        w_imm_sel = IMM_U; w_cw.rs1_sel = 1'b1; w_cw.rs2_sel = 1'b1;
        w_cw.m.wb = '{reg_we: 1'b1, reg_sel: 2'd1};
      end
      OPC_JAL: begin
        w_imm_sel = IMM_J; w_cw.m.jump = 1'b1;
        w_cw.m.wb = '{reg_we: 1'b1, reg_sel: 2'd3};
      end
      OPC_JALR: begin
        w_cw.rs2_sel = 1'b1; w_cw.m.jumpr = 1'b1; w_use_rs1 = 1'b1;
        w_cw.m.wb = '{reg_we: 1'b1, reg_sel: 2'd3};
      end
      OPC_BRANCH: begin
        w_imm_sel = IMM_B; w_cw.m.branch = 1'b1; w_cw.funct3 = w_f3;
        w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
        case (w_f3[2:1])
          2'b10:   w_cw.alu_sel = 4'b0010;
          2'b11:   w_cw.alu_sel = 4'b0011;
          default: w_cw.alu_sel = 4'b1000;
        endcase
      end
      OPC_LOAD: begin
        w_cw.rs2_sel = 1'b1; w_use_rs1 = 1'b1;
        w_cw.m.wb = '{reg_we: 1'b1, reg_sel: 2'd0};
      end
      OPC_STORE: begin
        w_imm_sel = IMM_S; w_cw.rs2_sel = 1'b1; w_cw.m.mem_we = 1'b1;
        w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
      end
      OPC_OPIMM: begin
        w_cw.rs2_sel = 1'b1; w_use_rs1 = 1'b1;
        w_cw.alu_sel = {bus.instr_D[30] & (w_f3 == 3'b101), w_f3};
        w_cw.m.wb = '{reg_we: 1'b1, reg_sel: 2'd1};
      end
      OPC_OP: begin
        w_cw.alu_sel = {bus.instr_D[30], w_f3};
        w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
        w_cw.m.wb = '{reg_we: 1'b1, reg_sel: 2'd1};
      end
      default: begin
        w_illegal = 1'b1;
        if (!NOP_ON_ILLEGAL) begin
          w_cw.rs2_sel = 1'b1; w_use_rs1 = 1'b1;
          w_cw.m.wb = '{reg_we: 1'b1, reg_sel: 2'd1};
        end
      end
    endcase
    w_cw.m.wb.reg_we = w_cw.m.wb.reg_we & (w_rd != '0);
    w_cw.m.rd        = w_cw.m.wb.reg_we ? w_rd : '0;
  end

  function automatic logic raw_hit(input cw_m_t cw, input logic [RF_AW-1:0] rs);
    return cw.wb.reg_we && (cw.rd == rs) && (rs != '0);
  endfunction

  assign w_raw = (w_use_rs1 && (raw_hit(r_cw_E.m, w_rs1) || raw_hit(r_cw_M, w_rs1))) ||
                 (w_use_rs2 && (raw_hit(r_cw_E.m, w_rs2) || raw_hit(r_cw_M, w_rs2)));

  // Branch condition from the ALU flags of the word currently in E
  always_comb begin
    w_taken_E = 1'b0;
    case (r_cw_E.funct3)
      3'b000:         w_taken_E = bus.alu_zero_E;
      3'b001:         w_taken_E = !bus.alu_zero_E;
      3'b100, 3'b110: w_taken_E = bus.alu_lsb_E;
      3'b101, 3'b111: w_taken_E = !bus.alu_lsb_E;
      default:        w_taken_E = 1'b0;
    endcase
    w_taken_E = w_taken_E & r_cw_E.m.branch;
  end

  assign w_pc_sel = (r_cw_M.jump || (r_cw_M.branch && r_taken_M)) ? 2'b11 :
                    r_cw_M.jumpr ? 2'b01 : 2'b00;
  assign w_xfer   = |w_pc_sel;

  // Stage registers; a redirect bubbles M too so it cannot fire twice
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cw_E    <= '0;
      r_cw_M    <= '0;
      r_cw_WB   <= '0;
      r_taken_M <= 1'b0;
    end else begin
      r_cw_E    <= (w_xfer || w_raw) ? '0 : w_cw;
      r_cw_M    <= w_xfer ? '0 : r_cw_E.m;
      r_taken_M <= w_xfer ? 1'b0 : w_taken_E;
      r_cw_WB   <= r_cw_M.wb;
    end
  end

  assign bus.imm_SEL   = w_imm_sel;
  assign bus.rs1_SEL   = r_cw_E.rs1_sel;
  assign bus.rs2_SEL   = r_cw_E.rs2_sel;
  assign bus.ALU_SEL   = r_cw_E.alu_sel;
  assign bus.mem_WE    = r_cw_M.mem_we;
  assign bus.pc_SEL    = w_pc_sel;
  assign bus.reg_WE    = r_cw_WB.reg_we;
  assign bus.reg_SEL   = r_cw_WB.reg_sel;
  assign bus.stall_F   = w_raw & ~w_xfer;
  assign bus.stall_D   = w_raw & ~w_xfer;
  assign bus.stall_E   = 1'b0;
  assign bus.stall_M   = 1'b0;
  assign bus.stall_WB  = 1'b0;
  assign bus.flush_D   = w_xfer;
  assign bus.flush_E   = w_xfer | w_raw;
  assign bus.flush_M   = w_xfer;
  assign bus.flush_WB  = 1'b0;
  assign bus.illegal_D = w_illegal;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: an instruction-level pipeline model predicts
// every cycle's outputs; a negedge monitor pops and compares.
module tb_pipe_ctrl;

  localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111,
                         JALR = 7'b1100111, BR = 7'b1100011, LD = 7'b0000011,
                         ST = 7'b0100011, OPI = 7'b0010011, OP = 7'b0110011;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipe_ctrl_if bus ();
  pipe_ctrl #(.RF_AW(5), .NOP_ON_ILLEGAL(1'b1)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [24:0] q[$];
  logic [31:0] src[$];
  logic [31:0] md, me, mm, mw;
  bit mtk;

  function automatic bit legal(input logic [31:0] i);
    return i[6:0] inside {LUI, AUIPC, JAL, JALR, BR, LD, ST, OPI, OP};
  endfunction
  function automatic bit writes(input logic [31:0] i);
    return (i[6:0] inside {LUI, AUIPC, JAL, JALR, LD, OPI, OP}) && (i[11:7] != 5'd0);
  endfunction
  function automatic bit reads1(input logic [31:0] i);
    return i[6:0] inside {JALR, BR, LD, ST, OPI, OP};
  endfunction
  function automatic bit reads2(input logic [31:0] i);
    return i[6:0] inside {OP, ST, BR};
  endfunction
  function automatic bit hits(input logic [31:0] x, input logic [4:0] rs);
    return writes(x) && (x[11:7] == rs) && (rs != 5'd0);
  endfunction
  function automatic logic [2:0] imm(input logic [31:0] i);
    case (i[6:0])
      ST: return 3'd1;
      BR: return 3'd2;
      LUI, AUIPC: return 3'd3;
      JAL: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction
  function automatic logic [3:0] alu(input logic [31:0] i);
    logic [2:0] f;
    f = i[14:12];
    case (i[6:0])
      BR:  return (f inside {3'd4, 3'd5}) ? 4'b0010 : (f inside {3'd6, 3'd7}) ? 4'b0011 : 4'b1000;
      OPI: return {1'(i[30] && f == 3'b101), f};
      OP:  return {i[30], f};
      default: return 4'b0000;
    endcase
  endfunction
  function automatic logic [1:0] regsel(input logic [31:0] i);
    case (i[6:0])
      LUI: return 2'd2;
      AUIPC, OPI, OP: return 2'd1;
      JAL, JALR: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction
  function automatic bit takes(input logic [31:0] i, input bit z, input bit l);
    if (i[6:0] != BR) return 1'b0;
    case (i[14:12])
      3'd0: return z;
      3'd1: return !z;
      3'd4, 3'd6: return l;
      3'd5, 3'd7: return !l;
      default: return 1'b0;
    endcase
  endfunction
  function automatic logic [1:0] pcsel(input logic [31:0] m, input bit tk);
    if (m[6:0] == JAL || (m[6:0] == BR && tk)) return 2'b11;
    if (m[6:0] == JALR) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [31:0] i;
    logic [2:0]  bf[6];
    bf = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    i = $urandom;
    i[11:7]  = 5'($urandom_range(0, 3));
    i[19:15] = 5'($urandom_range(0, 3));
    i[24:20] = 5'($urandom_range(0, 3));
    case ($urandom_range(0, 10))
      0: i[6:0] = LUI;
      1: i[6:0] = AUIPC;
      2: i[6:0] = JAL;
      3: i[6:0] = JALR;
      4: begin i[6:0] = BR; i[14:12] = bf[$urandom_range(0, 5)]; end
      5: i[6:0] = LD;
      6: i[6:0] = ST;
      7: i[6:0] = OPI;
      8, 9: i[6:0] = OP;
      default: i[6:0] = 7'b1111111;
    endcase
    return i;
  endfunction

  // One clock of stimulus plus the model's prediction and state advance
  task automatic cycle(input bit z, input bit l, input bit rnd);
    logic [31:0] nd;
    bit haz, xf;
    bus.instr_D = md; bus.alu_zero_E = z; bus.alu_lsb_E = l;
    haz = (reads1(md) && (hits(me, md[19:15]) || hits(mm, md[19:15]))) ||
          (reads2(md) && (hits(me, md[24:20]) || hits(mm, md[24:20])));
    xf = (pcsel(mm, mtk) != 2'b00);
    q.push_back({imm(md), 1'(me[6:0] == AUIPC), 1'(me[6:0] inside {AUIPC, JALR, LD, ST, OPI}),
                 alu(me), 1'(mm[6:0] == ST), pcsel(mm, mtk), 1'(writes(mw)), regsel(mw),
                 1'(haz && !xf), 1'(haz && !xf), 3'b000, 1'(xf), 1'(xf || haz), 1'(xf),
                 1'b0, 1'(!legal(md))});
    if (xf) nd = NOP;
    else if (haz) nd = md;
    else if (src.size() > 0) nd = src.pop_front();
    else if (rnd) nd = rnd_instr();
    else nd = NOP;
    @(posedge clk); #1;
    mw  = mm;
    mm  = xf ? 32'h0 : me;
    mtk = xf ? 1'b0 : takes(me, z, l);
    me  = (xf || haz || !legal(md)) ? 32'h0 : md;
    md  = nd;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    md = NOP; me = 32'h0; mm = 32'h0; mw = 32'h0; mtk = 1'b0;
  endtask

  task automatic run(input bit z);
    while (src.size() > 0) cycle(z, 1'b0, 1'b0);
    repeat (6) cycle(z, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    logic [24:0] exp_v, act_v;
    cyc++;
    if (q.size() > 0) begin
      exp_v = q.pop_front();
      act_v = {bus.imm_SEL, bus.rs1_SEL, bus.rs2_SEL, bus.ALU_SEL, bus.mem_WE, bus.pc_SEL,
               bus.reg_WE, bus.reg_SEL, bus.stall_F, bus.stall_D, bus.stall_E, bus.stall_M,
               bus.stall_WB, bus.flush_D, bus.flush_E, bus.flush_M, bus.flush_WB, bus.illegal_D};
      n_checks++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL outputs cyc%0d instr_D=%h got=%b exp=%b", cyc, bus.instr_D, act_v, exp_v);
      end
    end
  end

  initial begin
    reset = 1'b1;
    bus.instr_D = NOP; bus.alu_zero_E = 1'b0; bus.alu_lsb_E = 1'b0;
    md = NOP; me = 32'h0; mm = 32'h0; mw = 32'h0; mtk = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // reset with addi in E
    src = '{32'h0070_0293, 32'h0010_0313};
    repeat (3) cycle(1'b0, 1'b0, 1'b0);
    do_reset();
    src.delete();
    run(1'b0);
    // RAW on x5
    src = '{32'h0070_0293, 32'h0052_8333};
    run(1'b0);
    // rd = x0 never hazards
    src = '{32'h0010_0013, 32'h0000_0333};
    run(1'b0);
    // beq taken then not taken
    src = '{32'h0000_0463};
    run(1'b1);
    src = '{32'h0000_0463};
    run(1'b0);
    // jalr
    src = '{32'h0000_80E7};
    run(1'b0);
    // RAW-stalled consumer while JAL sits in M
    src = '{32'h0070_0293, 32'h0080_00EF, 32'h0010_8333};
    run(1'b0);

    repeat (800) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      else cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
    end
    run(1'b0);

    @(negedge clk); #1;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
